// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, response and shared-ALU signals of the arbiter
interface alu_share_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_setflags, req1_setflags;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags_q;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               req0_setflags, req1_setflags, alu_result, alu_flags,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, flags_q,
               alu_ctrl, alu_a, alu_b
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               req0_setflags, req1_setflags, alu_result, alu_flags,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, flags_q,
               alu_ctrl, alu_a, alu_b
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer time-sharing one ALU between two requesters
module alu_share_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic [3:0]  FLAG_RESET  = 4'b0000
) (
    input logic clk,
    input logic reset_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_next;
    logic        last_grant, owner, setflags;
    logic        any_valid, grant, done;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [3:0]  count;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, rsp_result;
    logic [3:0]  rsp_flags, flags_q;

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_flags  = rsp_flags;
    assign bus.flags_q    = flags_q;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;

    // Grant a lone requester; on conflict grant the one not served last; readies only in IDLE
    always_comb begin
        any_valid  = bus.req0_valid | bus.req1_valid;
        grant      = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        done       = (state == EXEC) && (count == 4'(EXEC_CYCLES - 1));
        req0_ready = (state == IDLE) & any_valid & ~grant;
        req1_ready = (state == IDLE) & any_valid & grant;
        state_next = (state == IDLE) ? (any_valid ? EXEC : IDLE) :
                     (state == EXEC) ? (done ? RESP : EXEC) : IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Operand launch on accept, settle count, result capture and architectural flag update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            setflags   <= 1'b0;
            count      <= 4'd0;
            alu_ctrl   <= 2'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            flags_q    <= FLAG_RESET;
        end else begin
            rsp0_valid <= done & ~owner;
            rsp1_valid <= done & owner;
            if (state == IDLE && any_valid) begin
                alu_ctrl   <= grant ? bus.req1_op : bus.req0_op;
                alu_a      <= grant ? bus.req1_a : bus.req0_a;
                alu_b      <= grant ? bus.req1_b : bus.req0_b;
                setflags   <= grant ? bus.req1_setflags : bus.req0_setflags;
                owner      <= grant;
                last_grant <= grant;
                count      <= 4'd0;
            end
            if (state == EXEC) count <= count + 4'd1;
            if (done) begin
                rsp_result <= bus.alu_result;
                rsp_flags  <= bus.alu_flags;
                if (setflags) flags_q <= alu_ctrl[1] ? {bus.alu_flags[3:2], flags_q[1:0]} : bus.alu_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed checks of the shared-ALU arbiter
module tb_alu_share_arbiter;
    localparam logic [3:0] FR1 = 4'b0000;
    localparam logic [3:0] FR3 = 4'b1010;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    int         passed = 0;
    int         total = 0;
    logic [3:0] mflags = FR1;

    alu_share_arbiter_if bus1 ();
    alu_share_arbiter_if bus3 ();

    alu_share_arbiter #(.EXEC_CYCLES(1), .FLAG_RESET(FR1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    alu_share_arbiter #(.EXEC_CYCLES(3), .FLAG_RESET(FR3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    always #5 clk = ~clk;

    // Reference ALU: {result, N, Z, C, V}; logical ops expose operand bits on C/V so preservation is visible
    function automatic logic [35:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = '0;
        c = a[0];
        v = b[0];
        if (op == 2'd0) begin
            w = {1'b0, a} + {1'b0, b};
            c = w[32];
            v = (a[31] == b[31]) && (w[31] != a[31]);
        end else if (op == 2'd1) begin
            w = {1'b0, a} + {1'b0, ~b} + 33'd1;
            c = w[32];
            v = (a[31] != b[31]) && (w[31] != a[31]);
        end
        r = (op == 2'd2) ? (a & b) : (op == 2'd3) ? (a | b) : w[31:0];
        return {r, r[31], r == 32'd0, c, v};
    endfunction

    always_comb {bus1.alu_result, bus1.alu_flags} = alu_ref(bus1.alu_ctrl, bus1.alu_a, bus1.alu_b);
    always_comb {bus3.alu_result, bus3.alu_flags} = alu_ref(bus3.alu_ctrl, bus3.alu_a, bus3.alu_b);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.req0_op = 0; bus1.req1_op = 0;
        bus1.req0_a = 0; bus1.req0_b = 0; bus1.req1_a = 0; bus1.req1_b = 0;
        bus1.req0_setflags = 0; bus1.req1_setflags = 0;
        bus3.req0_valid = 0; bus3.req1_valid = 0; bus3.req0_op = 0; bus3.req1_op = 0;
        bus3.req0_a = 0; bus3.req0_b = 0; bus3.req1_a = 0; bus3.req1_b = 0;
        bus3.req0_setflags = 0; bus3.req1_setflags = 0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mflags = FR1;
    endtask

    // Drives one request on bus1 and waits for its response; leaves time at the response negedge
    task automatic do_op(input bit who, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit sf, output int waited, output int lat,
                         output logic [31:0] eres, output logic [3:0] eflg);
        logic [35:0] e;
        bit acc;
        acc = 0; waited = -1; lat = -1;
        e = alu_ref(op, a, b);
        eres = e[35:4];
        eflg = e[3:0];
        if (who) begin
            bus1.req1_op = op; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_setflags = sf; bus1.req1_valid = 1;
        end else begin
            bus1.req0_op = op; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_setflags = sf; bus1.req0_valid = 1;
        end
        for (int w = 0; w < 20 && !acc; w++) begin
            #1;
            acc = who ? bus1.req1_ready : bus1.req0_ready;
            if (acc) waited = w;
            @(negedge clk);
        end
        if (who) bus1.req1_valid = 0; else bus1.req0_valid = 0;
        if (acc) begin
            for (int c = 0; c < 20 && lat < 0; c++) begin
                if (who ? bus1.rsp1_valid : bus1.rsp0_valid) lat = c;
                else @(negedge clk);
            end
            if (lat >= 0 && sf) mflags = op[1] ? {eflg[3:2], mflags[1:0]} : eflg;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus1.alu_ctrl !== 2'd0) $display("FAIL reset_alu_ctrl got %h expected 0", bus1.alu_ctrl); else passed++;
        total++; if ({bus1.alu_a, bus1.alu_b} !== 64'd0) $display("FAIL reset_alu_ab got %h expected 0", {bus1.alu_a, bus1.alu_b}); else passed++;
        total++; if ({bus1.rsp_result, bus1.rsp_flags} !== 36'd0) $display("FAIL reset_rsp got %h expected 0", {bus1.rsp_result, bus1.rsp_flags}); else passed++;
        total++; if ({bus1.rsp0_valid, bus1.rsp1_valid, bus1.req0_ready, bus1.req1_ready} !== 4'b0) $display("FAIL reset_strobes got %b expected 0000", {bus1.rsp0_valid, bus1.rsp1_valid, bus1.req0_ready, bus1.req1_ready}); else passed++;
        total++; if (bus1.flags_q !== FR1) $display("FAIL reset_flags1 got %b expected %b", bus1.flags_q, FR1); else passed++;
        total++; if (bus3.flags_q !== FR3) $display("FAIL reset_flags3 got %b expected %b", bus3.flags_q, FR3); else passed++;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        int w, l;
        logic [31:0] er;
        logic [3:0] ef;
        do_op(0, 2'd0, 32'h7FFFFFFF, 32'd1, 1, w, l, er, ef);
        total++; if (w !== 0) $display("FAIL add_ready_wait got %0d expected 0", w); else passed++;
        total++; if (l !== 1) $display("FAIL add_latency got %0d expected 1", l); else passed++;
        total++; if (bus1.rsp_result !== 32'h80000000) $display("FAIL add_result got %h expected 80000000", bus1.rsp_result); else passed++;
        total++; if (bus1.rsp_flags !== 4'b1001) $display("FAIL add_rsp_flags got %b expected 1001", bus1.rsp_flags); else passed++;
        total++; if (bus1.flags_q !== 4'b1001) $display("FAIL add_flags_q got %b expected 1001", bus1.flags_q); else passed++;
        total++; if (bus1.rsp1_valid !== 1'b0) $display("FAIL add_other_rsp got %b expected 0", bus1.rsp1_valid); else passed++;
        @(negedge clk);
        total++; if (bus1.rsp0_valid !== 1'b0) $display("FAIL add_pulse_width got %b expected 0", bus1.rsp0_valid); else passed++;
    endtask

    task automatic test_sub_cmp();
        int w, l;
        logic [31:0] er;
        logic [3:0] ef;
        do_op(1, 2'd1, 32'd5, 32'd5, 1, w, l, er, ef);
        total++; if (l !== 1) $display("FAIL sub_latency got %0d expected 1", l); else passed++;
        total++; if (bus1.rsp_result !== 32'd0) $display("FAIL sub_result got %h expected 0", bus1.rsp_result); else passed++;
        total++; if (bus1.rsp_flags !== 4'b0110) $display("FAIL sub_rsp_flags got %b expected 0110", bus1.rsp_flags); else passed++;
        total++; if (bus1.flags_q !== 4'b0110) $display("FAIL sub_flags_q got %b expected 0110", bus1.flags_q); else passed++;
        total++; if (bus1.rsp0_valid !== 1'b0) $display("FAIL sub_rsp0_quiet got %b expected 0", bus1.rsp0_valid); else passed++;
        @(negedge clk);
    endtask

    task automatic test_logic_flags();
        int w, l;
        logic [31:0] er;
        logic [3:0] ef;
        do_op(0, 2'd0, 32'h7FFFFFFF, 32'd1, 1, w, l, er, ef);
        do_op(0, 2'd2, 32'hF0, 32'h0F, 1, w, l, er, ef);
        total++; if (bus1.rsp_result !== 32'd0) $display("FAIL and_result got %h expected 0", bus1.rsp_result); else passed++;
        total++; if (bus1.flags_q !== 4'b0101) $display("FAIL and_flags_q got %b expected 0101", bus1.flags_q); else passed++;
        do_op(0, 2'd2, 32'hFFFFFFFF, 32'h80000000, 0, w, l, er, ef);
        total++; if (bus1.rsp_result !== 32'h80000000) $display("FAIL and_nosf_result got %h expected 80000000", bus1.rsp_result); else passed++;
        total++; if (bus1.flags_q !== 4'b0101) $display("FAIL and_nosf_flags_q got %b expected 0101", bus1.flags_q); else passed++;
        do_op(1, 2'd3, 32'h80000000, 32'h2, 1, w, l, er, ef);
        total++; if (bus1.rsp_flags !== 4'b1000) $display("FAIL or_rsp_flags got %b expected 1000", bus1.rsp_flags); else passed++;
        total++; if (bus1.flags_q !== 4'b1001) $display("FAIL or_flags_q got %b expected 1001", bus1.flags_q); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int g[4], t[4];
        int n, both;
        logic [35:0] e0, e1;
        bit r0, r1;
        apply_reset();
        n = 0; both = 0;
        for (int i = 0; i < 4; i++) begin g[i] = -1; t[i] = -1; end
        e0 = alu_ref(2'd0, 32'd1, 32'd1);
        e1 = alu_ref(2'd1, 32'd3, 32'd3);
        bus1.req0_op = 2'd0; bus1.req0_a = 32'd1; bus1.req0_b = 32'd1; bus1.req0_setflags = 1;
        bus1.req1_op = 2'd1; bus1.req1_a = 32'd3; bus1.req1_b = 32'd3; bus1.req1_setflags = 1;
        bus1.req0_valid = 1; bus1.req1_valid = 1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            #1;
            r0 = bus1.req0_ready;
            r1 = bus1.req1_ready;
            if (r0 && r1) both++;
            if (r0 || r1) begin
                g[n] = r1 ? 1 : 0;
                t[n] = cyc;
                mflags = r1 ? e1[3:0] : e0[3:0];
                n++;
            end
            @(negedge clk);
        end
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        repeat (3) @(negedge clk);
        total++; if (n !== 4) $display("FAIL b2b_accepts got %0d expected 4", n); else passed++;
        total++; if ({g[0], g[1], g[2], g[3]} !== {32'sd0, 32'sd1, 32'sd0, 32'sd1}) $display("FAIL b2b_order got %0d%0d%0d%0d expected 0101", g[0], g[1], g[2], g[3]); else passed++;
        for (int i = 1; i < 4; i++) begin
            total++; if (t[i] - t[i-1] !== 3) $display("FAIL b2b_spacing%0d got %0d expected 3", i, t[i] - t[i-1]); else passed++;
        end
        total++; if (both !== 0) $display("FAIL b2b_both_ready got %0d expected 0", both); else passed++;
        total++; if (bus1.flags_q !== mflags) $display("FAIL b2b_flags_q got %b expected %b", bus1.flags_q, mflags); else passed++;
    endtask

    task automatic test_busy_drop();
        int hits;
        bus1.req1_op = 2'd3; bus1.req1_a = 32'hF0; bus1.req1_b = 32'h0F; bus1.req1_setflags = 0; bus1.req1_valid = 1;
        #1;
        total++; if (bus1.req1_ready !== 1'b1) $display("FAIL drop_req1_ready got %b expected 1", bus1.req1_ready); else passed++;
        @(negedge clk);
        bus1.req1_valid = 0;
        bus1.req0_op = 2'd0; bus1.req0_a = 32'd1; bus1.req0_b = 32'd1; bus1.req0_setflags = 0; bus1.req0_valid = 1;
        #1;
        total++; if (bus1.req0_ready !== 1'b0) $display("FAIL drop_ready_exec got %b expected 0", bus1.req0_ready); else passed++;
        @(negedge clk);
        #1;
        total++; if (bus1.rsp1_valid !== 1'b1) $display("FAIL drop_rsp1 got %b expected 1", bus1.rsp1_valid); else passed++;
        total++; if (bus1.req0_ready !== 1'b0) $display("FAIL drop_ready_resp got %b expected 0", bus1.req0_ready); else passed++;
        total++; if (bus1.rsp_result !== 32'hFF) $display("FAIL drop_result got %h expected ff", bus1.rsp_result); else passed++;
        bus1.req0_valid = 0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus1.rsp0_valid || bus1.rsp1_valid) hits++;
        end
        total++; if (hits !== 0) $display("FAIL drop_no_accept got %0d expected 0", hits); else passed++;
    endtask

    task automatic test_exec3();
        int lat;
        bit stable;
        bus3.req0_op = 2'd0; bus3.req0_a = 32'd2; bus3.req0_b = 32'd3; bus3.req0_setflags = 0; bus3.req0_valid = 1;
        #1;
        total++; if (bus3.req0_ready !== 1'b1) $display("FAIL exec3_ready got %b expected 1", bus3.req0_ready); else passed++;
        @(negedge clk);
        bus3.req0_valid = 0;
        lat = -1; stable = 1;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            if (bus3.rsp0_valid) lat = c;
            else begin
                if (bus3.alu_a !== 32'd2 || bus3.alu_b !== 32'd3 || bus3.alu_ctrl !== 2'd0) stable = 0;
                @(negedge clk);
            end
        end
        total++; if (lat !== 3) $display("FAIL exec3_latency got %0d expected 3", lat); else passed++;
        total++; if (stable !== 1'b1) $display("FAIL exec3_operands_stable got %b expected 1", stable); else passed++;
        total++; if (bus3.rsp_result !== 32'd5) $display("FAIL exec3_result got %h expected 5", bus3.rsp_result); else passed++;
        total++; if (bus3.flags_q !== FR3) $display("FAIL exec3_flags_q got %b expected %b", bus3.flags_q, FR3); else passed++;
        @(negedge clk);
        total++; if ({bus3.rsp0_valid, bus3.alu_a, bus3.rsp_result} !== {1'b0, 32'd2, 32'd5}) $display("FAIL exec3_hold got %h expected %h", {bus3.rsp0_valid, bus3.alu_a, bus3.rsp_result}, {1'b0, 32'd2, 32'd5}); else passed++;
    endtask

    task automatic test_random();
        int w, l;
        bit who, sf;
        logic [1:0] op;
        logic [31:0] a, b, er;
        logic [3:0] ef;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            who = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            sf = 1'($urandom_range(0, 1));
            do_op(who, op, a, b, sf, w, l, er, ef);
            total++; if (l !== 1) $display("FAIL rnd%0d_latency got %0d expected 1", i, l); else passed++;
            total++; if (bus1.rsp_result !== er) $display("FAIL rnd%0d_result got %h expected %h", i, bus1.rsp_result, er); else passed++;
            total++; if (bus1.rsp_flags !== ef) $display("FAIL rnd%0d_rsp_flags got %b expected %b", i, bus1.rsp_flags, ef); else passed++;
            total++; if (bus1.flags_q !== mflags) $display("FAIL rnd%0d_flags_q got %b expected %b", i, bus1.flags_q, mflags); else passed++;
            total++; if ((who ? bus1.rsp0_valid : bus1.rsp1_valid) !== 1'b0) $display("FAIL rnd%0d_other_rsp got 1 expected 0", i); else passed++;
            total++; if ({bus1.alu_ctrl, bus1.alu_a, bus1.alu_b} !== {op, a, b}) $display("FAIL rnd%0d_alu_hold got %h expected %h", i, {bus1.alu_ctrl, bus1.alu_a, bus1.alu_b}, {op, a, b}); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int w, l, hits;
        logic [31:0] er;
        logic [3:0] ef;
        do_op(0, 2'd0, 32'h7FFFFFFF, 32'd1, 1, w, l, er, ef);
        @(negedge clk);
        bus1.req1_op = 2'd1; bus1.req1_a = 32'd9; bus1.req1_b = 32'd4; bus1.req1_setflags = 1; bus1.req1_valid = 1;
        #1;
        total++; if (bus1.req1_ready !== 1'b1) $display("FAIL rst_mid_ready got %b expected 1", bus1.req1_ready); else passed++;
        @(negedge clk);
        bus1.req1_valid = 0;
        reset_n = 1'b0;
        #1;
        total++; if (bus1.flags_q !== FR1) $display("FAIL rst_mid_flags_q got %b expected %b", bus1.flags_q, FR1); else passed++;
        total++; if ({bus1.alu_ctrl, bus1.alu_a, bus1.alu_b} !== 66'd0) $display("FAIL rst_mid_alu got %h expected 0", {bus1.alu_ctrl, bus1.alu_a, bus1.alu_b}); else passed++;
        total++; if ({bus1.rsp_result, bus1.rsp_flags} !== 36'd0) $display("FAIL rst_mid_rsp got %h expected 0", {bus1.rsp_result, bus1.rsp_flags}); else passed++;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin reset_n = 1'b1; mflags = FR1; end
            if (bus1.rsp0_valid || bus1.rsp1_valid) hits++;
        end
        total++; if (hits !== 0) $display("FAIL rst_mid_no_rsp got %0d expected 0", hits); else passed++;
        do_op(1, 2'd0, 32'd10, 32'd20, 1, w, l, er, ef);
        total++; if ({w, l} !== {32'sd0, 32'sd1}) $display("FAIL rst_mid_next_timing got %0d/%0d expected 0/1", w, l); else passed++;
        total++; if (bus1.rsp_result !== 32'd30) $display("FAIL rst_mid_next_result got %h expected 1e", bus1.rsp_result); else passed++;
        total++; if (bus1.flags_q !== mflags) $display("FAIL rst_mid_next_flags got %b expected %b", bus1.flags_q, mflags); else passed++;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        apply_reset();
        test_reset();
        test_add_overflow();
        test_sub_cmp();
        test_logic_flags();
        test_back_to_back();
        test_busy_drop();
        test_exec3();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
